// File: rtl/systolic_result_collector.sv
// Deskews diagonal systolic-array column results into aligned rows and buffers
// them in a first-word fall-through FIFO. Rows that arrive while the FIFO is full are dropped.
module systolic_result_collector #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_COLS   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_COLS*DATA_WIDTH-1:0] col_result,
  input  logic                           col0_valid,
  input  logic                           clear,
  output logic [NUM_COLS*DATA_WIDTH-1:0] out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                           overflow
);

  localparam int ROW_W = NUM_COLS * DATA_WIDTH;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  logic [ROW_W-1:0] aligned_row;
  logic             row_valid;

  // Column j is delayed NUM_COLS-1-j cycles so every element of a row lines up with the last column.
  for (genvar j = 0; j < NUM_COLS; j++) begin : g_col
    localparam int D = NUM_COLS - 1 - j;
    if (D == 0) begin : g_pass
      assign aligned_row[j*DATA_WIDTH +: DATA_WIDTH] = col_result[j*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] dly [D];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < D; k++) dly[k] <= '0;
        end else begin
          dly[0] <= col_result[j*DATA_WIDTH +: DATA_WIDTH];
          for (int k = 1; k < D; k++) dly[k] <= dly[k-1];
        end
      end
      assign aligned_row[j*DATA_WIDTH +: DATA_WIDTH] = dly[D-1];
    end
  end

  if (NUM_COLS > 1) begin : g_vpipe
    logic [NUM_COLS-2:0] vpipe;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vpipe <= '0;
      end else if (clear) begin
        vpipe <= '0;
      end else begin
        vpipe[0] <= col0_valid;
        for (int k = 1; k < NUM_COLS - 1; k++) vpipe[k] <= vpipe[k-1];
      end
    end
    assign row_valid = vpipe[NUM_COLS-2];
  end else begin : g_novpipe
    assign row_valid = col0_valid;
  end

  // Handshake: a row transfers on every rising edge where out_valid && out_ready;
  // out_valid never depends on out_ready and out_data holds while a row waits.
  logic [ROW_W-1:0] mem [FIFO_DEPTH];
  logic [ROW_W-1:0] last_q;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, do_pop, do_push, drop;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign do_pop    = out_valid && out_ready;
  assign do_push   = row_valid && (!full || do_pop);
  assign drop      = row_valid && full && !do_pop;
  assign out_data  = out_valid ? mem[rd_ptr] : last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      last_q   <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= aligned_row;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: doc/systolic_result_collector.md
Name: systolic_result_collector

Overview:
- Sits below the bottom row of a systolic PE array and is the reader for the results the PE columns produce.
- Column j produces its result for row r one cycle later than column j-1, so results leave the array on a diagonal.
- The block deskews these diagonal results into aligned row vectors and buffers them in a FIFO.
- Rows are presented downstream on a valid/ready handshake. The array cannot stall, so rows that do not fit are dropped and flagged.

Parameters:
- DATA_WIDTH, 8, width of one PE result (signed two's complement, passed through unmodified).
- NUM_COLS, 4, number of array columns, ≥1.
- FIFO_DEPTH, 4, number of aligned rows buffered, power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- col_result  in  NUM_COLS*DATA_WIDTH  bottom-row PE results; column j at bits [j*DATA_WIDTH +: DATA_WIDTH].
- col0_valid  in  1  column 0 carries a valid row result this cycle; column j's element of the same row arrives j cycles later.
- clear  in  1  synchronous flush.
- out_data  out  NUM_COLS*DATA_WIDTH  aligned row, same column packing as col_result.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accepts out_data this cycle.
- count  out  $clog2(FIFO_DEPTH+1)  rows currently stored.
- overflow  out  1  sticky: at least one row was dropped.

Behaviour:
- Reset (async, rst_n low):
  - All delay registers, valid pipeline, FIFO pointers, count and overflow clear to 0.
  - out_valid=0 and out_data=0.
  - Reset mid-row discards partial rows without any push.
- Deskew:
  - Column j passes through NUM_COLS-1-j registers; column NUM_COLS-1 uses 0 registers.
  - col0_valid passes through a NUM_COLS-1 stage shift pipeline, giving row_valid.
  - If col0_valid=1 at cycle t, the aligned row is present at the FIFO write port during cycle t+NUM_COLS-1.
  - Delay registers shift every cycle regardless of valid.
- Push: write at the clock edge ending the cycle where row_valid=1.
- Pop: occurs when out_valid && out_ready at the clock edge.
- out_data:
  - Driven from the read pointer entry (first-word fall-through).
  - Stable while out_valid=1 and out_ready=0.
  - Shows the last-read value when empty; it is not required to be 0 after the first write.
- Latency: col0_valid at cycle t gives out_valid=1 at cycle t+NUM_COLS when the FIFO was empty. This is one write cycle and zero read latency.
- Throughput: one row per cycle in and out; back-to-back col0_valid is allowed.
- Full handling:
  - Push while count==FIFO_DEPTH and no pop in the same cycle: the row is dropped, FIFO contents are unchanged, and overflow←1.
  - Push and pop in the same cycle while full: the push is accepted, count is unchanged, and there is no overflow.
- Empty handling:
  - Push and pop cannot coincide when count==0, because out_valid=0.
  - A push into an empty FIFO is visible the next cycle.
- count: incremented on a push-only cycle, decremented on a pop-only cycle, unchanged on both or neither.
- Pointers: log2(FIFO_DEPTH) bits; they wrap naturally from FIFO_DEPTH-1 to 0.
- clear (highest priority after reset):
  - Next edge: pointers, count and overflow go to 0.
  - The valid pipeline is zeroed, so rows in flight are discarded.
  - Data registers need not be cleared.
  - A push or pop in the same cycle as clear is ignored.
- NUM_COLS=1: no deskew registers; the row is pushed in the same cycle as col0_valid.
- No arithmetic is performed: widths are preserved and sign is irrelevant.

Test Plan:
- Single-row latency and alignment (NUM_COLS=4, DATA_WIDTH=8, FIFO_DEPTH=4):
  - Stimulus: col0_valid at t=10; column j is driven with 8'h10+j at cycle 10+j; out_ready=1.
  - Required: out_valid=1 only at cycle 14 with out_data=32'h13121110; count returns to 0 at cycle 15.
- Back-to-back rows:
  - Stimulus: col0_valid for 3 consecutive cycles with skewed rows A, B, C; out_ready=1.
  - Required: A, B, C are presented on 3 consecutive cycles in order with no gaps.
- Backpressure and overflow:
  - Stimulus: out_ready=0; 5 rows pushed.
  - Required: count=4; overflow=1 after the 5th row. Then setting out_ready=1 yields rows 1–4 only, overflow stays 1, and count reaches 0.
- Full with simultaneous push/pop:
  - Stimulus: fill to 4; assert out_ready=1 in the same cycle as the 5th row's push.
  - Required: count stays 4, overflow stays 0, and the 5th row is later delivered in order.
- Clear mid-flight:
  - Stimulus: 2 rows buffered, one row in the deskew pipeline, overflow=1; pulse clear.
  - Required: next cycle count=0, out_valid=0, overflow=0; the in-flight row never appears.
- Async reset mid-operation:
  - Stimulus: assert rst_n=0 between clock edges with count=3.
  - Required: out_valid=0, count=0 and out_data=0 immediately, without waiting for a clock edge. After release, a fresh row is delivered with NUM_COLS latency.
